dac_wave_source: RTL
====================

# dac_wave_source

Upstream sample generator for the SPI DAC serializer. Produces a 12-bit waveform (ramp up, ramp down, triangle, square) at a programmable sample rate and presents each sample on a valid/ready handshake that the serializer consumes once per 16-bit DAC frame. It replaces the serializer's free-running internal ramp with a rate-controlled, selectable source and reports when the consumer cannot keep up.

## Interface
- DATA_W, 12, sample width (DAC code width)
- DIV_W, 16, width of the sample-rate divider
- CNT_W, 8, width of the overrun counter
- clk  input  1  system clock; all logic rising-edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  run when high; low clears the generator (see Operation)
- mode  input  2  0 ramp up, 1 ramp down, 2 triangle, 3 square
- step  input  DATA_W  code increment per sample (ramp/triangle)
- rate_div  input  DIV_W  sample period = rate_div+1 clk cycles
- sample_data  output  DATA_W  current sample
- sample_valid  output  1  sample_data holds an unconsumed sample
- sample_ready  input  1  consumer accepts sample_data this cycle
- overrun  output  1  sticky: a tick was dropped because the holding register was full
- overrun_count  output  CNT_W  number of dropped ticks, saturating

## Operation
- Reset: div_cnt=0, acc=0, dir=up, sq=0, sample_data=0, sample_valid=0, overrun=0, overrun_count=0.
- enable low (reset low): div_cnt, acc, dir, sq, sample_valid cleared as at reset; sample_data cleared to 0; overrun/overrun_count retained (reset only). enable low may drop sample_valid without a handshake.
- Divider, each edge with enable high: if div_cnt >= rate_div then div_cnt<=0 and tick; else div_cnt<=div_cnt+1. Compare is >= so a reduced rate_div never causes a long wrap.
- On tick: emitted sample is current acc (square: sq ? max : 0, max = 2^DATA_W-1); acc/dir/sq advance per mode sampled on that edge:
  - ramp up: acc <= (acc+step) mod 2^DATA_W.
  - ramp down: acc <= (acc-step) mod 2^DATA_W.
  - triangle, dir up: if acc+step >= max (computed DATA_W+1 bits) acc<=max, dir<=down; else acc+=step. dir down: if acc <= step acc<=0, dir<=up; else acc-=step.
  - square: sq <= ~sq; acc unchanged.
- Holding register load on tick: if slot free (sample_valid=0, or sample_valid&sample_ready this edge) load sample_data, sample_valid<=1. Else keep old sample, set overrun<=1, overrun_count<=min(count+1, 2^CNT_W-1); generator still advances.
- Transfer: edge with sample_valid&sample_ready; sample_valid<=0 unless a tick loads a new sample on the same edge (stays 1, no overrun).
- mode/step changes take effect on the next tick; acc and dir are kept across mode changes. step=0: ramps/triangle hold value.

## Timing
- First tick on the (rate_div+1)th edge with enable high; sample_valid asserts after that edge with sample_data=0.
- Steady state: one tick every rate_div+1 cycles; rate_div=0 ticks every cycle.
- sample_data stable while sample_valid=1 and sample_ready=0.
- Latency tick edge -> sample_valid/sample_data visible: 0 extra cycles (registered at the tick edge).
- overrun and overrun_count update on the dropping tick edge.

## Test plan
- Ramp up, step=16, rate_div=3, sample_ready=1: samples 0,16,32,... every 4 cycles; 4080 followed by 0; overrun stays 0.
- Triangle, step=1000, rate_div=0, ready=1: 0,1000,2000,3000,4000,4095,3095,2095,1095,95,0,1000.
- Square, rate_div=9: alternating 0/4095 every 10 cycles.
- Backpressure: ramp up step=1, rate_div=1, ready held low 7 cycles from first valid: sample_data held at 0, overrun=1, overrun_count=3; on ready, next delivered sample is 4 (generator kept advancing).
- Tick and transfer on same edge: rate_div=0, ready=1 continuously: sample_valid never drops, every sample delivered once.
- enable low mid-run, then high: valid drops next edge, restart emits 0 after rate_div+1 edges; overrun_count unchanged; reset clears it to 0.

Source files
------------

// File: rtl/dac_wave_source_if.sv
// Sample handshake between the waveform source and the DAC serializer.
// The source drives data/valid; the consumer drives ready.
interface dac_wave_source_if #(
    parameter int unsigned DATA_W = 12
) ();

    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/dac_wave_source.sv
// Rate-controlled 12-bit waveform generator (ramp up/down, triangle, square) feeding the
// DAC serializer through a one-entry holding register with overrun reporting.
module dac_wave_source #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [DATA_W-1:0]     step,
    input  logic [DIV_W-1:0]      rate_div,
    dac_wave_source_if.master     smp,
    output logic                  overrun,
    output logic [CNT_W-1:0]      overrun_count
);

    typedef enum logic [1:0] {
        ModeRampUp   = 2'd0,
        ModeRampDown = 2'd1,
        ModeTriangle = 2'd2,
        ModeSquare   = 2'd3
    } mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    localparam logic [DATA_W-1:0] CODE_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    dir_e              dir_q, dir_d;
    logic              sq_q, sq_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  ovr_cnt_q, ovr_cnt_d;

    logic              tick;
    logic              slot_free;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] emitted;

    // Divider: >= compare so lowering rate_div mid-count never forces a full wrap.
    always_comb begin
        tick      = enable && (div_cnt_q >= rate_div);
        div_cnt_d = div_cnt_q;
        if (!enable || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, step};
        emitted = acc_q;
        if (mode_e'(mode) == ModeSquare) begin
            emitted = sq_q ? CODE_MAX : '0;
        end
    end

    // Waveform state; acc and dir persist across mode changes while enabled.
    always_comb begin
        acc_d = acc_q;
        dir_d = dir_q;
        sq_d  = sq_q;
        if (!enable) begin
            acc_d = '0;
            dir_d = DirUp;
            sq_d  = 1'b0;
        end else if (tick) begin
            unique case (mode_e'(mode))
                ModeRampUp: begin
                    acc_d = acc_q + step;
                end
                ModeRampDown: begin
                    acc_d = acc_q - step;
                end
                ModeTriangle: begin
                    if (dir_q == DirUp) begin
                        if (sum >= {1'b0, CODE_MAX}) begin
                            acc_d = CODE_MAX;
                            dir_d = DirDown;
                        end else begin
                            acc_d = sum[DATA_W-1:0];
                        end
                    end else begin
                        if (acc_q <= step) begin
                            acc_d = '0;
                            dir_d = DirUp;
                        end else begin
                            acc_d = acc_q - step;
                        end
                    end
                end
                ModeSquare: begin
                    sq_d = ~sq_q;
                end
            endcase
        end
    end

    // Holding register: a slot is free if empty or being drained on this edge.
    always_comb begin
        slot_free = !valid_q || smp.sample_ready;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        ovr_cnt_d = ovr_cnt_q;
        if (!enable) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (tick) begin
            if (slot_free) begin
                data_d  = emitted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
                if (ovr_cnt_q != CNT_MAX) begin
                    ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
                end
            end
        end else if (valid_q && smp.sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            acc_q     <= '0;
            dir_q     <= DirUp;
            sq_q      <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ovr_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            acc_q     <= acc_d;
            dir_q     <= dir_d;
            sq_q      <= sq_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign smp.sample_data  = data_q;
    assign smp.sample_valid = valid_q;
    assign overrun          = overrun_q;
    assign overrun_count    = ovr_cnt_q;

endmodule
